// File: rtl/sdram_vga_pkg.sv
// Shared definitions for the SDRAM-to-VGA path: fetcher state encoding,
// default video geometry and frame buffer base addresses.
`timescale 1ns/1ps
package sdram_vga_pkg;

    // Line fetcher control states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_REQ        = 2'd2,
        ST_RECV       = 2'd3
    } fetch_state_e;

    // Default geometry: 640x480 frame, 8-word SDRAM bursts
    localparam int DEF_LINE_WORDS = 640;
    localparam int DEF_NUM_LINES  = 480;
    localparam int DEF_BURST_LEN  = 8;

    // Frame buffer word addresses
    localparam logic [23:0] FB_BASE_A = 24'h000000;
    localparam logic [23:0] FB_BASE_B = 24'h080000;

endpackage

// File: rtl/sdram_line_fetcher_fetch_addr_gen.sv
// Address and position tracking for the line fetcher: current burst address,
// beat / burst / line counters and the last-beat / last-burst / last-line flags.
`timescale 1ns/1ps
module fetch_addr_gen
    import sdram_vga_pkg::*;
#(
    parameter int                  SDRAM_AW     = 24,
    parameter int                  BURST_LEN    = DEF_BURST_LEN,
    parameter int                  LINE_WORDS   = DEF_LINE_WORDS,
    parameter int                  NUM_LINES    = DEF_NUM_LINES,
    parameter logic [SDRAM_AW-1:0] FRAME_BASE_A = FB_BASE_A,
    parameter logic [SDRAM_AW-1:0] FRAME_BASE_B = FB_BASE_B
) (
    input  logic                clk_write,
    input  logic                rst_n,
    input  logic                load_i,       // reload base, clear all counters
    input  logic                sel_i,        // base select used by load_i (1 = buffer B)
    input  logic                beat_clr_i,   // start of a new burst
    input  logic                beat_inc_i,   // one returned beat accepted
    output logic [SDRAM_AW-1:0] addr_o,
    output logic                burst_last_o, // current beat is the last of the burst
    output logic                line_last_o,  // current burst is the last of the line
    output logic                frame_last_o  // current burst is the last of the frame
);

    localparam int BURSTS_PER_LINE = LINE_WORDS / BURST_LEN;
    localparam int BEAT_W  = $clog2(BURST_LEN) + 1;
    localparam int BURST_W = $clog2(BURSTS_PER_LINE) + 1;
    localparam int LINE_W  = $clog2(NUM_LINES) + 1;

    logic [SDRAM_AW-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                step;

    assign burst_last_o = (beat_q == BEAT_W'(BURST_LEN - 1));
    assign line_last_o  = (burst_q == BURST_W'(BURSTS_PER_LINE - 1));
    assign frame_last_o = line_last_o && (line_q == LINE_W'(NUM_LINES - 1));
    assign addr_o       = addr_q;

    // A burst completes when its final beat is accepted
    assign step = beat_inc_i && burst_last_o;

    // Next-state for address and counters; a reload wins over everything
    always_comb begin
        addr_d  = addr_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        line_d  = line_q;
        if (load_i) begin
            addr_d  = sel_i ? FRAME_BASE_B : FRAME_BASE_A;
            beat_d  = '0;
            burst_d = '0;
            line_d  = '0;
        end else begin
            if (beat_clr_i) begin
                beat_d = '0;
            end else if (beat_inc_i) begin
                beat_d = burst_last_o ? '0 : beat_q + 1'b1;
            end
            if (step) begin
                // Lines are contiguous, so the address simply advances (mod 2^SDRAM_AW)
                addr_d = addr_q + SDRAM_AW'(BURST_LEN);
                if (line_last_o) begin
                    burst_d = '0;
                    line_d  = frame_last_o ? '0 : line_q + 1'b1;
                end else begin
                    burst_d = burst_q + 1'b1;
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            beat_q  <= '0;
            burst_q <= '0;
            line_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: rtl/sdram_line_fetcher.sv
// SDRAM line fetcher: on frame start walks the frame buffer in fixed-length
// read bursts, issuing a burst only when the FIFO can absorb all of it, and
// forwards returned words to the FIFO write port with one cycle of latency.
// Optional build macro DOUBLE_BUFFER_EN adds buf_sel to choose buffer A or B
// at each accepted frame start.
`timescale 1ns/1ps
module sdram_line_fetcher
    import sdram_vga_pkg::*;
#(
    parameter int                  SDRAM_AW     = 24,
    parameter int                  DATA_WIDTH   = 16,
    parameter int                  FIFO_AW      = 11,
    parameter int                  BURST_LEN    = DEF_BURST_LEN,
    parameter int                  LINE_WORDS   = DEF_LINE_WORDS,
    parameter int                  NUM_LINES    = DEF_NUM_LINES,
    parameter logic [SDRAM_AW-1:0] FRAME_BASE_A = FB_BASE_A,
    parameter logic [SDRAM_AW-1:0] FRAME_BASE_B = FB_BASE_B
) (
    input  logic                  clk_write,
    input  logic                  rst_n,
    input  logic                  frame_start,
`ifdef DOUBLE_BUFFER_EN
    input  logic                  buf_sel,
`endif
    output logic                  rd_req,
    output logic [SDRAM_AW-1:0]   rd_addr,
    input  logic                  rd_ack,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [FIFO_AW:0]      fifo_free,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  busy,
    output logic                  line_done,
    output logic                  overflow_err
);

    localparam logic [FIFO_AW:0] BURST_ROOM = (FIFO_AW + 1)'(BURST_LEN);

    fetch_state_e          state_q, state_d;
    logic                  restart_pend_q, restart_pend_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  line_done_q, line_done_d;
    logic                  overflow_q, overflow_d;

    logic load, load_sel, beat_clr, beat_inc;
    logic burst_last, line_last, frame_last;
    logic restart_req;

    // A restart is due if one is pending or a new frame starts right now
    assign restart_req = restart_pend_q | frame_start;

`ifdef DOUBLE_BUFFER_EN
    logic sel_pend_q, sel_pend_d;
    // buf_sel is captured with the frame_start that requests the reload
    assign load_sel = frame_start ? buf_sel : sel_pend_q;
`else
    assign load_sel = 1'b0;
`endif

    fetch_addr_gen #(
        .SDRAM_AW    (SDRAM_AW),
        .BURST_LEN   (BURST_LEN),
        .LINE_WORDS  (LINE_WORDS),
        .NUM_LINES   (NUM_LINES),
        .FRAME_BASE_A(FRAME_BASE_A),
        .FRAME_BASE_B(FRAME_BASE_B)
    ) u_addr_gen (
        .clk_write   (clk_write),
        .rst_n       (rst_n),
        .load_i      (load),
        .sel_i       (load_sel),
        .beat_clr_i  (beat_clr),
        .beat_inc_i  (beat_inc),
        .addr_o      (rd_addr),
        .burst_last_o(burst_last),
        .line_last_o (line_last),
        .frame_last_o(frame_last)
    );

    assign rd_req       = (state_q == ST_REQ);
    assign busy         = (state_q != ST_IDLE);
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign line_done    = line_done_q;
    assign overflow_err = overflow_q;

    // Next-state and datapath control
    always_comb begin
        state_d        = state_q;
        restart_pend_d = restart_pend_q;
        wr_en_d        = 1'b0;
        wr_data_d      = wr_data_q;
        line_done_d    = 1'b0;
        overflow_d     = overflow_q | ((state_q == ST_RECV) && rd_valid && fifo_full);
        load           = 1'b0;
        beat_clr       = 1'b0;
        beat_inc       = 1'b0;
`ifdef DOUBLE_BUFFER_EN
        sel_pend_d     = sel_pend_q;
        if (frame_start && (state_q != ST_IDLE)) begin
            sel_pend_d = buf_sel;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    load    = 1'b1;
                    state_d = ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                // Burst boundary: a restart is applied here before any new request
                if (restart_req) begin
                    load           = 1'b1;
                    restart_pend_d = 1'b0;
                end else if (fifo_free >= BURST_ROOM) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (frame_start) begin
                    restart_pend_d = 1'b1;
                end
                if (rd_ack) begin
                    beat_clr = 1'b1;
                    state_d  = ST_RECV;
                end
            end
            ST_RECV: begin
                if (frame_start) begin
                    restart_pend_d = 1'b1;
                end
                if (rd_valid) begin
                    beat_inc  = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_data_d = rd_data;
                    if (burst_last) begin
                        line_done_d = line_last;
                        if (restart_req) begin
                            load           = 1'b1;
                            restart_pend_d = 1'b0;
                            state_d        = ST_WAIT_SPACE;
                        end else if (frame_last) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_SPACE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            restart_pend_q <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_data_q      <= '0;
            line_done_q    <= 1'b0;
            overflow_q     <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
            sel_pend_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            restart_pend_q <= restart_pend_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            line_done_q    <= line_done_d;
            overflow_q     <= overflow_d;
`ifdef DOUBLE_BUFFER_EN
            sel_pend_q     <= sel_pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Bench for sdram_line_fetcher with a reduced frame (64 words x 3 lines,
// 8-word bursts): a cycle-by-cycle vector table for the opening handshake,
// then directed sequences for full frame, backpressure, restart and overflow.
`timescale 1ns/1ps
module tb_sdram_line_fetcher;

    localparam int BL  = 8;
    localparam int LW  = 64;
    localparam int NL  = 3;
    localparam int BPF = (LW / BL) * NL;   // bursts per frame = 24

    logic        clk_write = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [11:0] fifo_free;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic        busy;
    logic        line_done;
    logic        overflow_err;
`ifdef DOUBLE_BUFFER_EN
    logic        buf_sel;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int ld_cnt = 0;
    bit mon_en = 1'b0;
    logic [15:0] next_data = 16'h0100;
    logic [15:0] exp_q[$];

    always #5 clk_write = ~clk_write;

    sdram_line_fetcher #(
        .LINE_WORDS(LW),
        .NUM_LINES (NL),
        .BURST_LEN (BL)
    ) dut (
        .clk_write   (clk_write),
        .rst_n       (rst_n),
        .frame_start (frame_start),
`ifdef DOUBLE_BUFFER_EN
        .buf_sel     (buf_sel),
`endif
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .fifo_free   (fifo_free),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .busy        (busy),
        .line_done   (line_done),
        .overflow_err(overflow_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-side scoreboard: every FIFO write must carry the next returned word
    always @(negedge clk_write) begin
        if (mon_en && rst_n) begin
            if (fifo_wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL wr_unexpected: write of 0x%0h with no word outstanding", fifo_wr_data);
                end else begin
                    check("wr_data", fifo_wr_data, exp_q.pop_front());
                end
            end
            if (line_done) ld_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_write);
        rst_n = 1'b1;
        @(posedge clk_write); #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk_write); #1;
        frame_start = 1'b0;
    endtask

    // One burst: wait for the request, check its address, ack after ack_delay
    // cycles, return BL beats. fs_beat / full_beat select beats carrying
    // frame_start / fifo_full (-1 for none).
    task automatic run_burst(input logic [23:0] exp_addr, input int ack_delay,
                             input int fs_beat, input int full_beat);
        int t = 0;
        while (rd_req !== 1'b1 && t < 300) begin
            @(posedge clk_write); #1;
            t++;
        end
        if (rd_req !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_timeout: rd_req=%b after 300 cycles, required 1 for addr 0x%0h", rd_req, exp_addr);
            return;
        end
        check("burst_addr", rd_addr, exp_addr);
        repeat (ack_delay) begin
            @(posedge clk_write); #1;
            check("hold_req", rd_req, 1);
            check("hold_addr", rd_addr, exp_addr);
        end
        rd_ack = 1'b1;
        @(posedge clk_write); #1;
        rd_ack = 1'b0;
        check("req_drop", rd_req, 0);
        for (int i = 0; i < BL; i++) begin
            rd_valid    = 1'b1;
            rd_data     = next_data;
            exp_q.push_back(next_data);
            next_data   = next_data + 16'd1;
            frame_start = (i == fs_beat);
            fifo_full   = (i == full_beat);
            @(posedge clk_write); #1;
            rd_valid    = 1'b0;
            frame_start = 1'b0;
            fifo_full   = 1'b0;
            if (i == full_beat) check("ovf_set", overflow_err, 1);
        end
    endtask

    typedef struct {
        logic        fs, ack, vld;
        logic [15:0] data;
        logic [11:0] free;
        logic        full;
        logic        req;
        logic [23:0] addr;
        logic        wen;
        logic [15:0] wdata;
        logic        busy, ldone, ovf;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // inputs: fs ack vld data free full | expected after the edge: req addr wen wdata busy ldone ovf
        tbl[0]  = '{0,0,0,16'h0000,12'd2048,0, 0,24'h0,0,16'h0000,0,0,0};
        tbl[1]  = '{0,0,1,16'hDEAD,12'd2048,0, 0,24'h0,0,16'h0000,0,0,0}; // rd_valid in IDLE ignored
        tbl[2]  = '{1,0,0,16'h0000,12'd7,   0, 0,24'h0,0,16'h0000,1,0,0}; // frame start
        tbl[3]  = '{0,0,0,16'h0000,12'd7,   0, 0,24'h0,0,16'h0000,1,0,0}; // no room
        tbl[4]  = '{0,0,0,16'h0000,12'd7,   0, 0,24'h0,0,16'h0000,1,0,0};
        tbl[5]  = '{0,0,0,16'h0000,12'd8,   0, 1,24'h0,0,16'h0000,1,0,0}; // room -> request
        tbl[6]  = '{0,0,0,16'h0000,12'd8,   0, 1,24'h0,0,16'h0000,1,0,0};
        tbl[7]  = '{0,1,0,16'h0000,12'd8,   0, 0,24'h0,0,16'h0000,1,0,0}; // ack
        tbl[8]  = '{0,0,1,16'h1000,12'd8,   0, 0,24'h0,1,16'h1000,1,0,0};
        tbl[9]  = '{0,0,0,16'h0000,12'd8,   0, 0,24'h0,0,16'h1000,1,0,0}; // gap in beats
        tbl[10] = '{0,0,1,16'h1001,12'd8,   0, 0,24'h0,1,16'h1001,1,0,0};
        tbl[11] = '{0,0,1,16'h1002,12'd8,   0, 0,24'h0,1,16'h1002,1,0,0};
        tbl[12] = '{0,0,1,16'h1003,12'd8,   0, 0,24'h0,1,16'h1003,1,0,0};
        tbl[13] = '{0,0,1,16'h1004,12'd8,   0, 0,24'h0,1,16'h1004,1,0,0};
        tbl[14] = '{0,0,1,16'h1005,12'd8,   0, 0,24'h0,1,16'h1005,1,0,0};
        tbl[15] = '{0,0,1,16'h1006,12'd8,   0, 0,24'h0,1,16'h1006,1,0,0};
        tbl[16] = '{0,0,1,16'h1007,12'd8,   0, 0,24'h8,1,16'h1007,1,0,0}; // last beat, addr steps
        tbl[17] = '{0,0,0,16'h0000,12'd8,   0, 1,24'h8,0,16'h1007,1,0,0}; // next request

        rst_n = 1'b0; frame_start = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0;
        rd_data = '0; fifo_free = 12'd2048; fifo_full = 1'b0;
`ifdef DOUBLE_BUFFER_EN
        buf_sel = 1'b0;
`endif
        #25;
        check("rst_req", rd_req, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_wen", fifo_wr_en, 0);
        check("rst_wdata", fifo_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ldone", line_done, 0);
        check("rst_ovf", overflow_err, 0);
        @(negedge clk_write);
        rst_n = 1'b1;
        @(posedge clk_write); #1;

        for (int i = 0; i < 18; i++) begin
            frame_start = tbl[i].fs;  rd_ack = tbl[i].ack; rd_valid = tbl[i].vld;
            rd_data = tbl[i].data;    fifo_free = tbl[i].free; fifo_full = tbl[i].full;
            @(posedge clk_write); #1;
            check($sformatf("row%0d_req", i),   rd_req,       tbl[i].req);
            check($sformatf("row%0d_addr", i),  rd_addr,      tbl[i].addr);
            check($sformatf("row%0d_wen", i),   fifo_wr_en,   tbl[i].wen);
            check($sformatf("row%0d_wdata", i), fifo_wr_data, tbl[i].wdata);
            check($sformatf("row%0d_busy", i),  busy,         tbl[i].busy);
            check($sformatf("row%0d_ldone", i), line_done,    tbl[i].ldone);
            check($sformatf("row%0d_ovf", i),   overflow_err, tbl[i].ovf);
        end
        frame_start = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0;

        // Backpressure: 50 cycles with room for 7, request one cycle after room for 8
        do_reset();
        fifo_free = 12'd7;
        pulse_fs();
        for (int c = 0; c < 50; c++) begin
            @(posedge clk_write); #1;
            check("bp_no_req", rd_req, 0);
        end
        fifo_free = 12'd8;
        @(posedge clk_write); #1;
        check("bp_req", rd_req, 1);

        // Full frame with ample space; burst 1 holds the ack for 10 cycles
        do_reset();
        fifo_free = 12'd2048;
        mon_en = 1'b1; wr_cnt = 0; ld_cnt = 0;
        pulse_fs();
        for (int b = 0; b < BPF; b++) begin
            run_burst(24'(b * BL), (b == 1) ? 10 : 2, -1, -1);
        end
        check("frame_end_busy", busy, 0);
        check("frame_end_wen", fifo_wr_en, 1);
        check("frame_end_ldone", line_done, 1);
        repeat (20) @(posedge clk_write);
        #1;
        check("idle_no_req", rd_req, 0);
        check("frame_writes", wr_cnt, BPF * BL);
        check("frame_lines", ld_cnt, NL);
        check("frame_queue_empty", exp_q.size(), 0);

        // Restart during beat 3 of burst 5 of line 2, then restart on the frame's last beat
        wr_cnt = 0; ld_cnt = 0;
        pulse_fs();
        for (int b = 0; b < 2 * (LW / BL) + 5; b++) begin
            run_burst(24'(b * BL), 2, -1, -1);
        end
        run_burst(24'((2 * (LW / BL) + 5) * BL), 2, 2, -1);
        check("restart_busy", busy, 1);
        check("restart_lines", ld_cnt, 2);
        for (int b = 0; b < BPF; b++) begin
            run_burst(24'(b * BL), 2, (b == BPF - 1) ? BL - 1 : -1, -1);
        end
        check("end_restart_busy", busy, 1);
        run_burst(24'h0, 2, -1, -1);
        @(posedge clk_write); #1;
        check("restart_lines_total", ld_cnt, 2 + NL);
        check("restart_writes", wr_cnt, (2 * (LW / BL) + 6) * BL + BPF * BL + BL);

        // Overflow is sticky until reset
        do_reset();
        check("rst_addr_again", rd_addr, 0);
        pulse_fs();
        run_burst(24'h0, 2, -1, 4);
        check("ovf_after_burst", overflow_err, 1);
        fifo_free = 12'd0;
        repeat (1000) @(posedge clk_write);
        #1;
        check("ovf_sticky", overflow_err, 1);
        check("ovf_wait_busy", busy, 1);
        check("ovf_wait_no_req", rd_req, 0);
        rst_n = 1'b0;
        #2;
        check("arst_ovf", overflow_err, 0);
        check("arst_addr", rd_addr, 0);
        check("arst_busy", busy, 0);
        check("arst_req", rd_req, 0);
        check("arst_wdata", fifo_wr_data, 0);
        @(negedge clk_write);
        rst_n = 1'b1;
        @(posedge clk_write); #1;
        fifo_free = 12'd2048;

`ifdef DOUBLE_BUFFER_EN
        // Buffer select latched at frame start only
        do_reset();
        buf_sel = 1'b1;
        pulse_fs();
        run_burst(24'h080000, 2, -1, -1);
        buf_sel = 1'b0;
        run_burst(24'h080008, 2, -1, -1);
        run_burst(24'h080010, 2, -1, -1);
        pulse_fs();
        run_burst(24'h000000, 2, -1, -1);
        @(posedge clk_write); #1;
`endif

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
